// File: rtl/fifo_pkg.sv
// Shared FIFO defaults and parameter-legality helpers for the single- and dual-clock FIFOs.
package fifo_pkg;

  localparam int unsigned DEF_DSIZE = 8;
  localparam int unsigned DEF_ASIZE = 4;

  // Thresholds must satisfy 0 <= aempty < afull <= depth.
  function automatic bit thresholds_legal(input int unsigned aempty_th,
                                          input int unsigned afull_th,
                                          input int unsigned depth);
    return (aempty_th < afull_th) && (afull_th <= depth);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: DEPTH x DSIZE register array, synchronous write, combinational read.
module sync_fifo_mem #(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned ASIZE = 4
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [ASIZE-1:0] waddr_i,
  input  logic [DSIZE-1:0] wdata_i,
  input  logic [ASIZE-1:0] raddr_i,
  output logic [DSIZE-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << ASIZE;

  logic [DSIZE-1:0] mem_q [DEPTH];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/empty thresholds, exact fill level,
// sticky overflow/underflow flags and a registered or first-word-fall-through read port.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int unsigned DSIZE     = DEF_DSIZE,
  parameter int unsigned ASIZE     = DEF_ASIZE,
  parameter int unsigned AFULL_TH  = 14,
  parameter int unsigned AEMPTY_TH = 2,
  parameter int unsigned FWFT      = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  input  logic             rinc,
  input  logic             err_clr,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned DEPTH = 1 << ASIZE;
  localparam int unsigned CW    = ASIZE + 1;

  if (!thresholds_legal(AEMPTY_TH, AFULL_TH, DEPTH)) begin : g_bad_thresholds
    $error("sync_fifo_prog: thresholds must satisfy AEMPTY_TH < AFULL_TH <= DEPTH");
  end

  logic [ASIZE-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wfull_q, wfull_d, rempty_q, rempty_d;
  logic             afull_q, afull_d, aempty_q, aempty_d;
  logic             ovf_q, ovf_d, udf_q, udf_d;
  logic             wr_acc, rd_acc;
  logic [DSIZE-1:0] mem_rdata;

  // Next-state: acceptance decided from registered flags; all flags derive from count_d.
  always_comb begin
    wr_acc  = winc && !wfull_q;
    rd_acc  = rinc && !rempty_q;
    waddr_d = waddr_q;
    raddr_d = raddr_q;
    if (wr_acc) waddr_d = waddr_q + ASIZE'(1);
    if (rd_acc) raddr_d = raddr_q + ASIZE'(1);
    count_d  = count_q + CW'(wr_acc) - CW'(rd_acc);
    wfull_d  = (count_d == CW'(DEPTH));
    rempty_d = (count_d == '0);
    afull_d  = (count_d >= CW'(AFULL_TH));
    aempty_d = (count_d <= CW'(AEMPTY_TH));
    // Set on a rejected request wins over a same-cycle clear.
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (err_clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (winc && wfull_q)  ovf_d = 1'b1;
    if (rinc && rempty_q) udf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waddr_q  <= '0;
      raddr_q  <= '0;
      count_q  <= '0;
      wfull_q  <= 1'b0;
      rempty_q <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      waddr_q  <= waddr_d;
      raddr_q  <= raddr_d;
      count_q  <= count_d;
      wfull_q  <= wfull_d;
      rempty_q <= rempty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  sync_fifo_mem #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (waddr_q),
    .wdata_i (wdata),
    .raddr_i (raddr_q),
    .rdata_o (mem_rdata)
  );

  if (FWFT != 0) begin : g_fwft
    // Head word is visible straight from the array, driven only by registered raddr.
    assign rdata = mem_rdata;
  end else begin : g_reg_read
    logic [DSIZE-1:0] rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      rdata_q <= '0;
      else if (rd_acc) rdata_q <= mem_rdata;
    end

    assign rdata = rdata_q;
  end

  assign wfull        = wfull_q;
  assign rempty       = rempty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: registered-read and FWFT instances share stimulus and are
// compared every cycle against a queue-based reference model.
module tb_sync_fifo_prog;

  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] wdata;
  logic       winc, rinc, err_clr;

  logic [7:0] rdata0, rdata1;
  logic       wfull0, rempty0, af0, ae0, ovf0, udf0;
  logic       wfull1, rempty1, af1, ae1, ovf1, udf1;
  logic [4:0] count0, count1;

  always #5 clk = ~clk;

  sync_fifo_prog #(.DSIZE(8), .ASIZE(4), .AFULL_TH(14), .AEMPTY_TH(2), .FWFT(0)) dut_reg (
    .clk(clk), .rst_n(rst_n), .wdata(wdata), .winc(winc), .rinc(rinc), .err_clr(err_clr),
    .rdata(rdata0), .wfull(wfull0), .rempty(rempty0), .almost_full(af0),
    .almost_empty(ae0), .count(count0), .overflow(ovf0), .underflow(udf0)
  );

  sync_fifo_prog #(.DSIZE(8), .ASIZE(4), .AFULL_TH(14), .AEMPTY_TH(2), .FWFT(1)) dut_fwft (
    .clk(clk), .rst_n(rst_n), .wdata(wdata), .winc(winc), .rinc(rinc), .err_clr(err_clr),
    .rdata(rdata1), .wfull(wfull1), .rempty(rempty1), .almost_full(af1),
    .almost_empty(ae1), .count(count1), .overflow(ovf1), .underflow(udf1)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] q[$];
  logic       ovf_m, udf_m;
  logic [7:0] rd0_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    ovf_m = 1'b0;
    udf_m = 1'b0;
    rd0_m = 8'h00;
  endtask

  task automatic model_step(input logic w, input logic r, input logic [7:0] d, input logic e);
    bit full, empty;
    full  = (q.size() == DEPTH);
    empty = (q.size() == 0);
    if (e) begin
      ovf_m = 1'b0;
      udf_m = 1'b0;
    end
    if (w && full)  ovf_m = 1'b1;
    if (r && empty) udf_m = 1'b1;
    if (r && !empty) rd0_m = q.pop_front();
    if (w && !full) q.push_back(d);
  endtask

  task automatic check_all();
    int         n;
    logic [10:0] st_exp;
    n = q.size();
    check("count", 32'(count0), 32'(n));
    check("wfull", 32'(wfull0), 32'(n == DEPTH));
    check("rempty", 32'(rempty0), 32'(n == 0));
    check("almost_full", 32'(af0), 32'(n >= AF));
    check("almost_empty", 32'(ae0), 32'(n <= AE));
    check("overflow", 32'(ovf0), 32'(ovf_m));
    check("underflow", 32'(udf0), 32'(udf_m));
    check("rdata_reg", 32'(rdata0), 32'(rd0_m));
    st_exp = {n == DEPTH, n == 0, n >= AF, n <= AE, ovf_m, udf_m, 5'(n)};
    check("fwft_status", 32'({wfull1, rempty1, af1, ae1, ovf1, udf1, count1}), 32'(st_exp));
    if (n > 0) check("rdata_fwft", 32'(rdata1), 32'(q[0]));
  endtask

  // Inputs change on the falling edge; outputs are checked on the next falling edge.
  task automatic cycle(input logic w, input logic r, input logic [7:0] d, input logic e);
    winc    = w;
    rinc    = r;
    wdata   = d;
    err_clr = e;
    @(posedge clk);
    model_step(w, r, d, e);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst_n   = 1'b0;
    winc    = 1'b0;
    rinc    = 1'b0;
    err_clr = 1'b0;
    wdata   = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Fill with 0x00..0x0F, then one write too many.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 8'(i), 1'b0);
    cycle(1'b1, 1'b0, 8'hEE, 1'b0);

    // Drain in order, then one read too many; registered rdata must hold 0x0F.
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    check("rdata_hold", 32'(rdata0), 32'h0F);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);

    // Full with simultaneous write and read.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 8'($urandom), 1'b0);
    cycle(1'b1, 1'b1, 8'h77, 1'b0);
    while (q.size() > 0) cycle(1'b0, 1'b1, 8'h00, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);

    // Empty with simultaneous write and read.
    cycle(1'b1, 1'b1, 8'hA5, 1'b0);
    check("fwft_a5", 32'(rdata1), 32'hA5);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);

    // Half full, 40 cycles of streaming through: pointers wrap repeatedly.
    while (q.size() < 8) cycle(1'b1, 1'b0, 8'($urandom), 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, 8'(8'h40 + i), 1'b0);

    // Sticky overflow: set wins over clear, clear alone releases it.
    while (q.size() < DEPTH) cycle(1'b1, 1'b0, 8'($urandom), 1'b0);
    cycle(1'b1, 1'b0, 8'h11, 1'b0);
    cycle(1'b1, 1'b0, 8'h22, 1'b1);
    check("ovf_set_wins", 32'(ovf0), 32'h1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);

    // Random traffic with occasional error clears.
    for (int i = 0; i < 800; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
            1'($urandom_range(0, 15) == 0));
    end

    // Asynchronous reset mid-stream: outputs must drop without a clock edge.
    while (q.size() < 5) cycle(1'b1, 1'b0, 8'($urandom), 1'b0);
    winc  = 1'b1;
    rinc  = 1'b1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    winc = 1'b0;
    rinc = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 200; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
            1'($urandom_range(0, 15) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
